// File: rtl/xor_arb_pkg.sv
// Shared definitions for the XOR round-robin arbiter.
// Optional build macro used by the top: XOR_ARB_STATS_EN (adds txn_count).
package xor_arb_pkg;

  // Sequencer states: grant in IDLE, compute in CALC, hand off in DONE
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of the completed-transaction counter
  localparam int TXN_W = 16;

endpackage

// File: rtl/xor_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Returns the first set request found searching upward from i_ptr with wrap
// at N_REQ. Works for non-power-of-2 N_REQ because only indices that exist
// are ever produced.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [ID_W-1:0]  o_winner,
  output logic             o_any
);

  logic [ID_W-1:0] w_hi_idx;
  logic [ID_W-1:0] w_lo_idx;
  logic            w_hi_found;

  // Lowest set index at/above ptr (hi) and lowest set index overall (lo, the wrap case)
  always_comb begin
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    w_hi_found = 1'b0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (i_req[j]) begin
        w_lo_idx = ID_W'(j);
        if (ID_W'(j) >= i_ptr) begin
          w_hi_idx   = ID_W'(j);
          w_hi_found = 1'b1;
        end
      end
    end
  end

  assign o_any    = |i_req;
  assign o_winner = w_hi_found ? w_hi_idx : w_lo_idx;

endmodule

// File: rtl/xor_rr_arbiter.sv
// xor_rr_arbiter: shares one registered XOR datapath among N_REQ requesters.
// Optional build macro: XOR_ARB_STATS_EN adds a saturating 16-bit txn_count.
//
// Handshake: a result transfers on a rising edge where out_valid and
// out_ready are both high; out_valid, out_y and out_id are held stable
// until that edge. On the request side, ack[i] is a one-cycle pulse marking
// the edge at which requester i's operands were captured.
module xor_rr_arbiter
  import xor_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 8,
  localparam int ID_W  = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_bus,
  input  logic [N_REQ*WIDTH-1:0] b_bus,
  output logic [N_REQ-1:0]       ack,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_y,
  output logic [ID_W-1:0]        out_id,
`ifdef XOR_ARB_STATS_EN
  output logic [TXN_W-1:0]       txn_count,
`endif
  output logic                   busy
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_win;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [N_REQ-1:0]  r_ack;
  logic              r_valid;
  logic [WIDTH-1:0]  r_y;
  logic [ID_W-1:0]   r_id;

  logic [ID_W-1:0]   w_win;
  logic              w_any;
  logic              w_grant;
  logic              w_hs;
  logic [ID_W-1:0]   w_ptr_nxt;
  logic [WIDTH-1:0]  w_a_sel;
  logic [WIDTH-1:0]  w_b_sel;
  logic [N_REQ-1:0]  w_ack_onehot;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_winner (w_win),
    .o_any    (w_any)
  );

  assign w_grant   = (r_state == IDLE) && w_any;
  assign w_hs      = (r_state == DONE) && r_valid && out_ready;
  assign w_ptr_nxt = (r_win == ID_W'(N_REQ - 1)) ? '0 : r_win + 1'b1;

  // Select the winner's operand slices and build its one-hot ack
  always_comb begin
    w_a_sel      = '0;
    w_b_sel      = '0;
    w_ack_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win == ID_W'(i)) begin
        w_a_sel         = a_bus[i*WIDTH +: WIDTH];
        w_b_sel         = b_bus[i*WIDTH +: WIDTH];
        w_ack_onehot[i] = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_nxt = CALC;
      CALC:    w_state_nxt = DONE;
      DONE:    if (w_hs) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: capture at grant, compute in CALC, release on handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= '0;
      r_win   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_ack   <= '0;
      r_valid <= 1'b0;
      r_y     <= '0;
      r_id    <= '0;
    end else begin
      r_ack <= w_grant ? w_ack_onehot : '0;
      if (w_grant) begin
        r_a   <= w_a_sel;
        r_b   <= w_b_sel;
        r_win <= w_win;
      end
      if (r_state == CALC) begin
        r_y     <= r_a ^ r_b;
        r_id    <= r_win;
        r_valid <= 1'b1;
      end
      if (w_hs) begin
        r_valid <= 1'b0;
        r_ptr   <= w_ptr_nxt;
      end
    end
  end

`ifdef XOR_ARB_STATS_EN
  logic [TXN_W-1:0] r_txn_count;

  // Count completed handshakes, saturating at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_txn_count <= '0;
    else if (w_hs && (r_txn_count != {TXN_W{1'b1}}))
      r_txn_count <= r_txn_count + 1'b1;
  end

  assign txn_count = r_txn_count;
`endif

  assign ack       = r_ack;
  assign out_valid = r_valid;
  assign out_y     = r_y;
  assign out_id    = r_id;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_xor_rr_arbiter.sv
// Testbench for xor_rr_arbiter (N_REQ = 4, WIDTH = 8).
// Directed vectors with hand-computed results; a monitor compares acks and
// delivered results against expected queues.
module tb_xor_rr_arbiter;
  import xor_arb_pkg::*;

  localparam int N_REQ = 4;
  localparam int WIDTH = 8;
  localparam int ID_W  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] a_bus;
  logic [N_REQ*WIDTH-1:0] b_bus;
  logic [N_REQ-1:0]       ack;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_y;
  logic [ID_W-1:0]        out_id;
  logic                   busy;
`ifdef XOR_ARB_STATS_EN
  logic [TXN_W-1:0]       txn_count;
`endif

  xor_rr_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_bus     (a_bus),
    .b_bus     (b_bus),
    .ack       (ack),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_id    (out_id),
`ifdef XOR_ARB_STATS_EN
    .txn_count (txn_count),
`endif
    .busy      (busy)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [N_REQ-1:0]        exp_ack_q[$];
  logic [ID_W+WIDTH-1:0]   exp_res_q[$];
  logic [N_REQ-1:0]        mon_ack_e;
  logic [ID_W+WIDTH-1:0]   mon_res_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    a_bus[i*WIDTH +: WIDTH] = a;
    b_bus[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic wait_ack(input string name, output logic [N_REQ-1:0] got);
    logic seen;
    seen = 1'b0;
    got  = '0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      if (ack != '0) begin
        got  = ack;
        seen = 1'b1;
      end
    end
    if (!seen) fail_now(name);
  endtask

  task automatic wait_idle(input string name);
    logic done;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      step();
      if (!busy && !out_valid) done = 1'b1;
    end
    if (!done) fail_now(name);
  endtask

  task automatic wait_valid(input string name);
    logic done;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      step();
      if (out_valid) done = 1'b1;
    end
    if (!done) fail_now(name);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (ack != '0) begin
      if (exp_ack_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ack_unexpected: got %b expected none", ack);
      end else begin
        mon_ack_e = exp_ack_q.pop_front();
        check("ack_seq", 32'(ack), 32'(mon_ack_e));
      end
    end
    if (out_valid && out_ready) begin
      if (exp_res_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL res_unexpected: got id=%0d y=%0h expected none", out_id, out_y);
      end else begin
        mon_res_e = exp_res_q.pop_front();
        check("res_id_y", 32'({out_id, out_y}), 32'(mon_res_e));
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [N_REQ-1:0] got;
  int n_ack;

  initial begin
    rst       = 1'b1;
    req       = 4'b1111;
    a_bus     = '0;
    b_bus     = '0;
    out_ready = 1'b0;

    // Reset holds everything quiet even with all requests high
    repeat (3) step();
    check("rst_ack",   32'(ack), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_y",     32'(out_y), 32'h0);
    check("rst_id",    32'(out_id), 32'h0);
    req = '0;
    rst = 1'b0;
    step();

    // Single request: A5 ^ 0F = AA from requester 0
    set_op(0, 8'hA5, 8'h0F);
    out_ready = 1'b1;
    exp_ack_q.push_back(4'b0001);
    exp_res_q.push_back({2'd0, 8'hAA});
    req = 4'b0001;
    step();
    check("single_ack",  32'(ack), 32'h1);
    check("single_busy", 32'(busy), 32'h1);
    req = '0;
    step();
    check("single_valid", 32'(out_valid), 32'h1);
    check("single_y",     32'(out_y), 32'hAA);
    check("single_id",    32'(out_id), 32'h0);
    step();
    check("single_busy_drop", 32'(busy), 32'h0);

    // Fairness from ptr = 0: all four held, five grants
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_op(0, 8'h11, 8'h22);  // 33
    set_op(1, 8'h0F, 8'hF0);  // FF
    set_op(2, 8'h3C, 8'h00);  // 3C
    set_op(3, 8'h81, 8'h18);  // 99
    exp_ack_q.push_back(4'b0001); exp_res_q.push_back({2'd0, 8'h33});
    exp_ack_q.push_back(4'b0010); exp_res_q.push_back({2'd1, 8'hFF});
    exp_ack_q.push_back(4'b0100); exp_res_q.push_back({2'd2, 8'h3C});
    exp_ack_q.push_back(4'b1000); exp_res_q.push_back({2'd3, 8'h99});
    exp_ack_q.push_back(4'b0001); exp_res_q.push_back({2'd0, 8'h33});
    req   = 4'b1111;
    n_ack = 0;
    for (int k = 0; k < 5; k++) begin
      wait_ack("fair_ack_wait", got);
      if (got != '0) n_ack++;
    end
    req = '0;
    check("fair_grants", 32'(n_ack), 32'd5);
    wait_idle("fair_idle");

    // Backpressure: result 3C held while requester 2 waits
    out_ready = 1'b0;
    exp_ack_q.push_back(4'b0100);
    exp_res_q.push_back({2'd2, 8'h3C});
    req = 4'b0100;
    wait_ack("bp_ack1", got);
    req = '0;
    wait_valid("bp_valid_wait");
    set_op(2, 8'h55, 8'hAA);  // FF
    exp_ack_q.push_back(4'b0100);
    exp_res_q.push_back({2'd2, 8'hFF});
    req = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_hold_valid", 32'(out_valid), 32'h1);
      check("bp_hold_y",     32'(out_y), 32'h3C);
      check("bp_hold_ack",   32'(ack), 32'h0);
    end
    out_ready = 1'b1;
    step();
    check("bp_idle_ack", 32'(ack), 32'h0);
    step();
    check("bp_late_ack", 32'(ack), 32'h4);
    req = '0;
    set_op(2, 8'h00, 8'h00);  // operands after the grant must be ignored
    wait_idle("bp_idle");

    // Mid-operation reset during CALC, requester 0 granted from ptr = 3
    set_op(0, 8'h11, 8'h22);
    req = 4'b0001;
    wait_ack("mid_ack", got);
    req = '0;
    rst = 1'b1;
    #1;
    check("mid_grant",     32'(got), 32'h1);
    check("mid_ack_clear", 32'(ack), 32'h0);
    check("mid_busy",      32'(busy), 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("mid_no_valid", 32'(out_valid), 32'h0);
    end
    rst = 1'b0;
    exp_ack_q.push_back(4'b0010); exp_res_q.push_back({2'd1, 8'hFF});
    exp_ack_q.push_back(4'b1000); exp_res_q.push_back({2'd3, 8'h99});
    req = 4'b1010;
    wait_ack("mid_post_ack1", got);
    check("mid_post_first", 32'(got), 32'h2);
    wait_ack("mid_post_ack2", got);
    check("mid_post_second", 32'(got), 32'h8);
    req = '0;
    wait_idle("mid_idle");

`ifdef XOR_ARB_STATS_EN
    // Two handshakes since the last reset
    check("stats_count", 32'(txn_count), 32'd2);
    force dut.r_txn_count = 16'hFFFE;
    step();
    release dut.r_txn_count;
    exp_ack_q.push_back(4'b0001); exp_res_q.push_back({2'd0, 8'h33});
    exp_ack_q.push_back(4'b0010); exp_res_q.push_back({2'd1, 8'hFF});
    req = 4'b0001;
    wait_ack("stats_ack1", got);
    req = '0;
    wait_idle("stats_idle1");
    check("stats_reach_max", 32'(txn_count), 32'hFFFF);
    req = 4'b0010;
    wait_ack("stats_ack2", got);
    req = '0;
    wait_idle("stats_idle2");
    check("stats_saturate", 32'(txn_count), 32'hFFFF);
`endif

    repeat (2) step();
    check("ack_q_drained", 32'(exp_ack_q.size()), 32'd0);
    check("res_q_drained", 32'(exp_res_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
